avalon_pio_param: RTL and testbench
===================================

Name: avalon_pio_param

Overview:
- Parametrised Avalon-MM PIO slave; next generation of the single-register LED output port.
- Adds configurable width, per-bit direction, atomic bit set/clear, synchronised inputs, edge capture and a maskable interrupt.
- Sits in the NIOS_core system between the Avalon interconnect and board I/O (LEDs, keys, switches, GPIO headers). Tristate buffers live at top level, driven by out_port/out_en.

Parameters:
WIDTH, 16, port width in bits, legal 1..32
RESET_VALUE, 0, reset value of the output data register (low WIDTH bits used)
DIR_RESET, 0, reset value of direction register; 1 = output
EDGE_TYPE, 1, capture mode: 0 none, 1 rising, 2 falling, 3 any
SYNC_STAGES, 2, input synchroniser depth, legal 2..4

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  3  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe, valid with chipselect
read_n  in  1  active-low read strobe, valid with chipselect
writedata  in  32  write data; bits above WIDTH ignored
readdata  out  32  registered read data; bits above WIDTH read 0
in_port  in  WIDTH  asynchronous external inputs
out_port  out  WIDTH  output data register
out_en  out  WIDTH  direction register; 1 = drive pin
irq  out  1  level interrupt

Behaviour:
- One clock. Reset is asynchronous and active-high: assertion takes effect immediately, release is sampled on clk.
- Reset values:
  - data_out = RESET_VALUE, dir = DIR_RESET.
  - irq_mask = 0, edge_capture = 0.
  - All synchroniser and previous-sample flops = 0.
  - readdata = 0, irq = 0.
- Register map (address: read / write):
  - 0: pin data / data_out <= wd
  - 1: dir / dir <= wd
  - 2: irq_mask / irq_mask <= wd
  - 3: edge_capture / write-1-to-clear
  - 4: 0 / data_out <= data_out | wd (set)
  - 5: 0 / data_out <= data_out & ~wd (clear)
  - 6, 7: read 0, writes ignored
- Write: takes effect at the clk edge where chipselect=1 and write_n=0. Visible on out_port/out_en the following cycle.
- Read:
  - Latency 1. readdata is registered at the edge where chipselect=1 and read_n=0.
  - Otherwise readdata holds its last value.
  - Address 0 returns, per bit: data_out where dir=1, in_sync where dir=0.
- Input path:
  - in_port passes through a SYNC_STAGES flop chain to give in_sync, then one more flop gives in_prev.
  - Edge detect is combinational from in_sync/in_prev:
    - rise = in_sync & ~in_prev
    - fall = ~in_sync & in_prev
    - any = rise | fall
  - Edge detect is applied to all bits regardless of dir.
- Edge capture:
  - A detected edge sets the matching edge_capture bit on the next clk edge.
  - Timing: an in_port change set up before edge k sets edge_capture at edge k+SYNC_STAGES.
  - EDGE_TYPE=0: edge_capture is constant 0 and writes to address 3 are ignored.
- Simultaneous events:
  - Edge detected on the same cycle as a W1C write to that bit: the set wins, bit stays 1.
  - A write to address 0/4/5 in the same cycle as a read of address 0: readdata returns the pre-write value.
- irq = |(edge_capture & irq_mask), registered. It asserts one cycle after the capture bit or mask bit becomes 1, and deasserts one cycle after the clear.
- Level inputs with no edge never raise irq.
- Reset mid-operation: all state returns to reset values immediately, and an in-flight read returns 0. Edges occurring while reset is asserted are lost.
- Back-to-back writes every cycle are supported, with no wait states.

Decomposition:
- Package pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_DIR=1, ADDR_MASK=2, ADDR_EDGE=3, ADDR_SET=4, ADDR_CLR=5
  - EDGE_NONE/RISE/FALL/ANY encodings
- One sub-module, pio_in_sync: parametrised by WIDTH, SYNC_STAGES and EDGE_TYPE; outputs in_sync and the edge vector.

Test Plan:
- Reset release, WIDTH=16, RESET_VALUE=16'hA5A5 -> out_port=A5A5, out_en=0, irq=0. Read address 2 -> 0.
- Write addr0=0x00FF, addr4=0x0F00, addr5=0x000F -> out_port=0x0FF0. Read addr 4 -> 0.
- dir=0xFF00, out=0x1234, in_port=0xABCD -> read addr0 returns 0x12CD, one cycle after the read strobe.
- EDGE_TYPE=1, SYNC_STAGES=2, mask=0x0001, in_port[0] 0->1 before edge k -> edge_capture[0]=1 at k+2, irq=1 at k+3. W1C 0x1 -> irq=0 one cycle after clear.
- Rising edge on bit 3 in the same cycle as W1C 0x8 -> edge_capture[3] remains 1. Falling edge with EDGE_TYPE=1 -> no capture.
- Assert reset mid-read with edge_capture=0xF -> readdata, edge_capture and irq go to 0 without waiting for clk. out_port=RESET_VALUE.

Source files
------------

// File: rtl/avalon_pio_param_pkg.sv
// Shared constants for the parametrised Avalon-MM PIO: register map and edge-capture modes.
package pio_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_DIR  = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  localparam int unsigned EDGE_NONE = 0;
  localparam int unsigned EDGE_RISE = 1;
  localparam int unsigned EDGE_FALL = 2;
  localparam int unsigned EDGE_ANY  = 3;

  typedef struct packed {
    logic wr;
    logic rd;
  } bus_strobe_t;

  // Decode Avalon strobes; both are qualified by chipselect and active low.
  function automatic bus_strobe_t decode_strobe(logic chipselect, logic write_n, logic read_n);
    bus_strobe_t s;
    s.wr = chipselect & ~write_n;
    s.rd = chipselect & ~read_n;
    return s;
  endfunction

endpackage

// File: rtl/avalon_pio_param_if.sv
// Avalon-MM slave bus bundle for the PIO register block.
interface avalon_pio_param_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output read_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  read_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/avalon_pio_param_in_sync.sv
// Input synchroniser chain plus one history flop; produces the synchronised value and the
// per-bit edge vector selected by EDGE_TYPE.
module pio_in_sync
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_det
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];
  assign rise    = in_sync & ~prev_q;
  assign fall    = ~in_sync & prev_q;

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_det = rise;
      EDGE_FALL: edge_det = fall;
      EDGE_ANY:  edge_det = rise | fall;
      default:   edge_det = '0;
    endcase
  end

endmodule

// File: rtl/avalon_pio_param.sv
// Parametrised Avalon-MM PIO slave: data/direction registers, atomic set/clear,
// synchronised inputs with edge capture and a maskable level interrupt.
module avalon_pio_param
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter logic [31:0] DIR_RESET   = 32'h0,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  avalon_pio_param_if.slave   bus,
  input  logic [WIDTH-1:0]    in_port,
  output logic [WIDTH-1:0]    out_port,
  output logic [WIDTH-1:0]    out_en,
  output logic                irq
);

  bus_strobe_t      strobe;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_det;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] pin_val;
  logic [WIDTH-1:0] rd_field;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  assign strobe = decode_strobe(bus.chipselect, bus.write_n, bus.read_n);
  assign wd     = bus.writedata[WIDTH-1:0];

  if (WIDTH < 32) begin : g_wd_unused
    logic unused_wd_hi;
    assign unused_wd_hi = ^bus.writedata[31:WIDTH];
  end

  pio_in_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_in_sync (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .in_sync (in_sync),
    .edge_det(edge_det)
  );

  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    w1c    = '0;
    if (strobe.wr) begin
      case (bus.address)
        ADDR_DATA: data_d = wd;
        ADDR_DIR:  dir_d  = wd;
        ADDR_MASK: mask_d = wd;
        ADDR_EDGE: w1c    = wd;
        ADDR_SET:  data_d = data_q | wd;
        ADDR_CLR:  data_d = data_q & ~wd;
        default:   ;
      endcase
    end
  end

  // A newly detected edge overrides a same-cycle clear so no event is lost.
  always_comb begin
    edge_d = '0;
    if (EDGE_TYPE != EDGE_NONE) begin
      edge_d = (edge_q & ~w1c) | edge_det;
    end
  end

  // Reads sample pre-write register state, so a same-cycle write is not yet visible.
  always_comb begin
    pin_val  = (data_q & dir_q) | (in_sync & ~dir_q);
    rd_field = '0;
    case (bus.address)
      ADDR_DATA: rd_field = pin_val;
      ADDR_DIR:  rd_field = dir_q;
      ADDR_MASK: rd_field = mask_q;
      ADDR_EDGE: rd_field = edge_q;
      default:   rd_field = '0;
    endcase
    readdata_d = readdata_q;
    if (strobe.rd) begin
      readdata_d              = '0;
      readdata_d[WIDTH-1:0]   = rd_field;
    end
    irq_d = |(edge_q & mask_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= RESET_VALUE[WIDTH-1:0];
      dir_q      <= DIR_RESET[WIDTH-1:0];
      mask_q     <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_q     <= data_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign out_port     = data_q;
  assign out_en       = dir_q;
  assign irq          = irq_q;
  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_avalon_pio_param.sv
// Directed bench for avalon_pio_param: register-map vector table plus hand-built sequences
// for input sync, edge capture, interrupt timing and asynchronous reset.
module tb_avalon_pio_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_port;
  logic [15:0] out_port;
  logic [15:0] out_en;
  logic        irq;

  int passed = 0;
  int total  = 0;

  avalon_pio_param_if bus_if ();

  avalon_pio_param #(
    .WIDTH      (16),
    .RESET_VALUE(32'h0000_A5A5),
    .DIR_RESET  (32'h0),
    .EDGE_TYPE  (1),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .in_port (in_port),
    .out_port(out_port),
    .out_en  (out_en),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [15:0] exp_out;
    logic [15:0] exp_en;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else passed++;
  endtask

  task automatic idle();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.read_n     = 1'b1;
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_wr(input logic [2:0] addr, input logic [31:0] data);
    bus_if.address    = addr;
    bus_if.writedata  = data;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    tick();
    idle();
  endtask

  task automatic bus_rd(input logic [2:0] addr);
    bus_if.address    = addr;
    bus_if.chipselect = 1'b1;
    bus_if.read_n     = 1'b0;
    tick();
    idle();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3'd2, 32'h0,         16'hA5A5, 16'h0000, 32'h0};
    vecs[1]  = '{1'b1, 3'd0, 32'h0000_00FF, 16'h00FF, 16'h0000, 32'h0};
    vecs[2]  = '{1'b1, 3'd4, 32'h0000_0F00, 16'h0FFF, 16'h0000, 32'h0};
    vecs[3]  = '{1'b1, 3'd5, 32'h0000_000F, 16'h0FF0, 16'h0000, 32'h0};
    vecs[4]  = '{1'b0, 3'd4, 32'h0,         16'h0FF0, 16'h0000, 32'h0};
    vecs[5]  = '{1'b0, 3'd0, 32'h0,         16'h0FF0, 16'h0000, 32'h0};
    vecs[6]  = '{1'b1, 3'd1, 32'h0000_FF00, 16'h0FF0, 16'hFF00, 32'h0};
    vecs[7]  = '{1'b1, 3'd0, 32'hFFFF_1234, 16'h1234, 16'hFF00, 32'h0};
    vecs[8]  = '{1'b0, 3'd1, 32'h0,         16'h1234, 16'hFF00, 32'h0000_FF00};
    vecs[9]  = '{1'b0, 3'd0, 32'h0,         16'h1234, 16'hFF00, 32'h0000_1200};
    vecs[10] = '{1'b1, 3'd2, 32'hFFFF_0001, 16'h1234, 16'hFF00, 32'h0};
    vecs[11] = '{1'b0, 3'd2, 32'h0,         16'h1234, 16'hFF00, 32'h0000_0001};
    vecs[12] = '{1'b1, 3'd6, 32'h0000_FFFF, 16'h1234, 16'hFF00, 32'h0};
    vecs[13] = '{1'b0, 3'd7, 32'h0,         16'h1234, 16'hFF00, 32'h0};
    vecs[14] = '{1'b0, 3'd2, 32'h0,         16'h1234, 16'hFF00, 32'h0000_0001};
    vecs[15] = '{1'b0, 3'd6, 32'h0,         16'h1234, 16'hFF00, 32'h0};
    vecs[16] = '{1'b1, 3'd2, 32'h0,         16'h1234, 16'hFF00, 32'h0};
    vecs[17] = '{1'b0, 3'd2, 32'h0,         16'h1234, 16'hFF00, 32'h0};

    reset            = 1'b1;
    in_port          = '0;
    bus_if.address   = '0;
    bus_if.writedata = '0;
    idle();
    tick(2);
    check("reset out_port", 32'(out_port), 32'h0000_A5A5);
    check("reset out_en", 32'(out_en), 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    check("reset readdata", bus_if.readdata, 32'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].data);
      else bus_rd(vecs[i].addr);
      check($sformatf("vec%0d out_port", i), 32'(out_port), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d out_en", i), 32'(out_en), 32'(vecs[i].exp_en));
      check($sformatf("vec%0d irq", i), 32'(irq), 32'h0);
      if (!vecs[i].wr) check($sformatf("vec%0d readdata", i), bus_if.readdata, vecs[i].exp_rd);
    end

    // Mixed pin read, then read and write of address 0 in the same cycle.
    in_port = 16'hABCD;
    tick(3);
    bus_rd(3'd0);
    check("pin read mixed", bus_if.readdata, 32'h0000_12CD);
    bus_if.address    = 3'd0;
    bus_if.writedata  = 32'h0000_00FF;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.read_n     = 1'b0;
    tick();
    idle();
    check("rd+wr pre-write value", bus_if.readdata, 32'h0000_12CD);
    check("rd+wr out_port", 32'(out_port), 32'h0000_00FF);
    bus_rd(3'd0);
    check("pin read after write", bus_if.readdata, 32'h0000_00CD);
    bus_rd(3'd3);
    check("rising capture all", bus_if.readdata, 32'h0000_ABCD);
    check("masked-off irq", 32'(irq), 32'h0);
    in_port = 16'h0000;
    tick(4);
    bus_wr(3'd3, 32'h0000_FFFF);
    bus_rd(3'd3);
    check("w1c all", bus_if.readdata, 32'h0);

    // Capture and irq latency for a rising edge on bit 0.
    bus_wr(3'd2, 32'h0000_0001);
    in_port = 16'h0001;
    tick(2);
    bus_if.address    = 3'd3;
    bus_if.chipselect = 1'b1;
    bus_if.read_n     = 1'b0;
    tick();
    check("capture at k+2 not yet", bus_if.readdata, 32'h0);
    check("irq at k+2", 32'(irq), 32'h0);
    tick();
    idle();
    check("capture at k+3 visible", bus_if.readdata, 32'h0000_0001);
    check("irq at k+3", 32'(irq), 32'h1);
    bus_wr(3'd3, 32'h0000_0001);
    check("irq holds at clear edge", 32'(irq), 32'h1);
    tick();
    check("irq drops after clear", 32'(irq), 32'h0);

    // Bit 3: rising captured, falling ignored, set beats a same-cycle clear.
    in_port = 16'h0009;
    tick(4);
    bus_rd(3'd3);
    check("bit3 rise", bus_if.readdata, 32'h0000_0008);
    bus_wr(3'd3, 32'h0000_0008);
    in_port = 16'h0001;
    tick(4);
    bus_rd(3'd3);
    check("falling ignored", bus_if.readdata, 32'h0);
    in_port = 16'h0009;
    tick(2);
    bus_wr(3'd3, 32'h0000_0008);
    bus_rd(3'd3);
    check("set wins over w1c", bus_if.readdata, 32'h0000_0008);
    check("unmasked bit no irq", 32'(irq), 32'h0);

    // Build edge_capture = 0xF, then reset in the middle of a read.
    bus_wr(3'd2, 32'h0000_000F);
    in_port = 16'h0008;
    tick(4);
    in_port = 16'h000F;
    tick(4);
    bus_rd(3'd3);
    check("capture 0xF", bus_if.readdata, 32'h0000_000F);
    check("irq before reset", 32'(irq), 32'h1);
    bus_if.address    = 3'd3;
    bus_if.chipselect = 1'b1;
    bus_if.read_n     = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async reset readdata", bus_if.readdata, 32'h0);
    check("async reset irq", 32'(irq), 32'h0);
    check("async reset out_port", 32'(out_port), 32'h0000_A5A5);
    check("async reset out_en", 32'(out_en), 32'h0);
    @(negedge clk);
    idle();
    in_port = 16'h0000;
    tick(2);
    reset = 1'b0;
    tick();
    bus_rd(3'd3);
    check("edge after reset", bus_if.readdata, 32'h0);
    bus_rd(3'd2);
    check("mask after reset", bus_if.readdata, 32'h0);
    check("irq after reset", 32'(irq), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
